// File: rtl/vector_packer_if.sv
// Stream bundle for vector_packer: element input stream, vector output stream
// and the fill-level observation port.
interface vector_packer_if #(
  parameter int DIM = 8,
  parameter int W   = 64
);
  localparam int CW = $clog2(DIM) + 1;

  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             in_ready;
  logic [DIM*W-1:0] vector;
  logic             vec_valid;
  logic             vec_ready;
  logic [CW-1:0]    fill_count;

  modport master (
    output in_valid, in_data, in_last, vec_ready,
    input  in_ready, vector, vec_valid, fill_count
  );

  modport slave (
    input  in_valid, in_data, in_last, vec_ready,
    output in_ready, vector, vec_valid, fill_count
  );
endinterface

// File: rtl/vector_packer.sv
// Serial-to-parallel packer: one W-bit element per cycle into DIM-lane vectors,
// double-buffered so input can stream while a finished vector awaits its consumer.
module vector_packer #(
  parameter int DIM = 8,
  parameter int W   = 64
) (
  input logic            Clock,
  input logic            Reset,
  vector_packer_if.slave bus
);
  localparam int IW = $clog2(DIM);
  localparam int CW = IW + 1;

  logic [DIM*W-1:0] slot [2];
  logic [1:0]       full;
  logic             wsel;
  logic             rsel;
  logic [IW-1:0]    idx;

  logic acc;
  logic close;
  logic drain;

  // in_ready depends only on registered state and Reset, never on in_valid.
  assign bus.in_ready   = ~Reset & ~full[wsel];
  assign acc            = bus.in_valid & bus.in_ready;
  assign close          = acc & ((idx == IW'(DIM - 1)) | bus.in_last);
  assign drain          = full[rsel] & bus.vec_ready;

  assign bus.vec_valid  = full[rsel];
  assign bus.vector     = slot[rsel];
  assign bus.fill_count = CW'(idx);

  // NOTE: every register here is updated with <= so all reads in this block
  // see pre-edge values; close and drain then touch disjoint bits of full.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      full    <= '0;
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      idx     <= '0;
      // NOTE: the slots are cleared on reset because vector must read as zero
      // straight out of reset; this is visible state, not scratch storage.
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      if (acc) begin
        // Lane 0 wipes the rest of the slot so a short vector is zero-filled.
        for (int lane = 0; lane < DIM; lane++) begin
          if (IW'(lane) == idx)
            slot[wsel][W*lane +: W] <= bus.in_data;
          else if (idx == '0)
            slot[wsel][W*lane +: W] <= '0;
        end
        if (close) begin
          full[wsel] <= 1'b1;
          wsel       <= ~wsel;
          idx        <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
      // A close needs full[wsel]=0 and a drain needs full[rsel]=1, so the two
      // always address different slots when they coincide.
      if (drain) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end
    end
  end
endmodule

// File: tb/tb_vector_packer.sv
// Self-checking bench for vector_packer (DIM=4, W=16): directed table, hand
// sequences for backpressure/overlap/reset, then random traffic vs a queue model.
module tb_vector_packer;
  localparam int DIM = 4;
  localparam int W   = 16;

  logic Clock;
  logic Reset;

  vector_packer_if #(.DIM(DIM), .W(W)) bus ();

  vector_packer #(.DIM(DIM), .W(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] d;
    logic        last;
    logic        vr;
    logic        e_ready;
    logic        e_valid;
    logic [63:0] e_vec;
    logic [2:0]  e_fill;
  } row_t;

  row_t tbl [17];

  // Reference model: completed vectors in a FIFO of depth 2, partial vector as a list.
  logic [63:0] mq [$];
  logic [15:0] part [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [15:0] d,
                       input logic last, input logic vr);
    @(negedge Clock);
    Reset         = rst;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.vec_ready = vr;
    #1;
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [15:0] d,
                            input logic last, input logic vr);
    logic        rdy;
    logic        val;
    logic [63:0] packed_vec;
    if (rst) begin
      mq.delete();
      part.delete();
    end else begin
      rdy = (mq.size() < 2);
      val = (mq.size() > 0);
      if (val && vr) void'(mq.pop_front());
      if (v && rdy) begin
        part.push_back(d);
        if (part.size() == DIM || last) begin
          packed_vec = '0;
          foreach (part[i]) packed_vec[16*i +: 16] = part[i];
          mq.push_back(packed_vec);
          part.delete();
        end
      end
    end
  endtask

  initial begin
    int          nxt;
    logic        r_rst;
    logic        r_v;
    logic        r_last;
    logic        r_vr;
    logic [15:0] r_d;

    Reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.vec_ready = 1'b0;

    // Reset, with an element offered that must be dropped.
    drive(1, 1, 16'h0099, 0, 0);
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    drive(1, 1, 16'h0099, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("post_rst_ready", 64'(bus.in_ready), 64'(1));
    check("post_rst_valid", 64'(bus.vec_valid), 64'(0));
    check("post_rst_vector", bus.vector, 64'(0));
    check("post_rst_fill", 64'(bus.fill_count), 64'(0));

    //             rst v  d        last vr  ready valid vector                fill
    tbl[0]  = '{0, 1, 16'h0001, 0, 1,  1, 0, 64'h0,                 3'd0};
    tbl[1]  = '{0, 1, 16'h0002, 0, 1,  1, 0, 64'h0,                 3'd1};
    tbl[2]  = '{0, 1, 16'h0003, 0, 1,  1, 0, 64'h0,                 3'd2};
    tbl[3]  = '{0, 1, 16'h0004, 0, 1,  1, 0, 64'h0,                 3'd3};
    tbl[4]  = '{0, 0, 16'h0000, 0, 1,  1, 1, 64'h0004_0003_0002_0001, 3'd0};
    tbl[5]  = '{0, 1, 16'h00AA, 0, 0,  1, 0, 64'h0,                 3'd0};
    tbl[6]  = '{0, 1, 16'h00BB, 1, 0,  1, 0, 64'h0,                 3'd1};
    tbl[7]  = '{0, 0, 16'h0000, 0, 0,  1, 1, 64'h0000_0000_00BB_00AA, 3'd0};
    tbl[8]  = '{0, 1, 16'h0001, 0, 1,  1, 1, 64'h0000_0000_00BB_00AA, 3'd0};
    tbl[9]  = '{0, 1, 16'h0002, 0, 0,  1, 0, 64'h0,                 3'd1};
    tbl[10] = '{0, 1, 16'h0003, 0, 0,  1, 0, 64'h0,                 3'd2};
    tbl[11] = '{0, 1, 16'h0004, 0, 0,  1, 0, 64'h0,                 3'd3};
    tbl[12] = '{0, 0, 16'h0000, 0, 1,  1, 1, 64'h0004_0003_0002_0001, 3'd0};
    tbl[13] = '{0, 1, 16'h1234, 1, 0,  1, 0, 64'h0,                 3'd0};
    tbl[14] = '{0, 0, 16'h0000, 0, 0,  1, 1, 64'h0000_0000_0000_1234, 3'd0};
    tbl[15] = '{0, 0, 16'h0000, 0, 1,  1, 1, 64'h0000_0000_0000_1234, 3'd0};
    tbl[16] = '{0, 0, 16'h0000, 0, 0,  1, 0, 64'h0,                 3'd0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].vr);
      check($sformatf("tbl%0d_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_ready));
      check($sformatf("tbl%0d_valid", i), 64'(bus.vec_valid), 64'(tbl[i].e_valid));
      check($sformatf("tbl%0d_fill", i), 64'(bus.fill_count), 64'(tbl[i].e_fill));
      if (tbl[i].e_valid)
        check($sformatf("tbl%0d_vector", i), bus.vector, tbl[i].e_vec);
    end

    // Backpressure: 1..12 offered with the consumer stalled; exactly 8 fit.
    nxt = 1;
    for (int c = 0; c < 12; c++) begin
      drive(0, 1, 16'(nxt), 0, 0);
      if (c >= 4) begin
        check("bp_hold_valid", 64'(bus.vec_valid), 64'(1));
        check("bp_hold_vector", bus.vector, 64'h0004_0003_0002_0001);
      end
      if (bus.in_ready) nxt++;
    end
    check("bp_accepts", 64'(nxt - 1), 64'(8));
    drive(0, 1, 16'(nxt), 0, 1);
    check("bp_full_ready", 64'(bus.in_ready), 64'(0));
    drive(0, 1, 16'(nxt), 0, 0);
    check("bp_next_vector", bus.vector, 64'h0008_0007_0006_0005);
    check("bp_resume_ready", 64'(bus.in_ready), 64'(1));
    if (bus.in_ready) nxt++;
    for (int c = 0; c < 5; c++) begin
      drive(0, nxt <= 12, 16'(nxt), 0, 0);
      if (bus.in_ready && nxt <= 12) nxt++;
    end
    check("bp_all_accepted", 64'(nxt - 1), 64'(12));
    check("bp_full_again", 64'(bus.in_ready), 64'(0));
    drive(0, 0, 0, 0, 1);
    check("bp_drain1", bus.vector, 64'h0008_0007_0006_0005);
    drive(0, 0, 0, 0, 1);
    check("bp_drain2", bus.vector, 64'h000C_000B_000A_0009);
    drive(0, 0, 0, 0, 0);
    check("bp_empty", 64'(bus.vec_valid), 64'(0));

    // Close of S1 coinciding with drain of S0: vec_valid stays high.
    for (int k = 1; k <= 7; k++) drive(0, 1, 16'(k), 0, 0);
    drive(0, 1, 16'h0008, 0, 1);
    check("ov_valid_before", 64'(bus.vec_valid), 64'(1));
    check("ov_vector_before", bus.vector, 64'h0004_0003_0002_0001);
    drive(0, 0, 0, 0, 0);
    check("ov_valid_after", 64'(bus.vec_valid), 64'(1));
    check("ov_vector_after", bus.vector, 64'h0008_0007_0006_0005);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    check("ov_empty", 64'(bus.vec_valid), 64'(0));

    // Reset with one full slot and a half-filled one.
    for (int k = 1; k <= 6; k++) drive(0, 1, 16'(k), 0, 0);
    drive(1, 1, 16'h0077, 0, 0);
    check("mr_ready_in_reset", 64'(bus.in_ready), 64'(0));
    drive(0, 0, 0, 0, 0);
    check("mr_valid", 64'(bus.vec_valid), 64'(0));
    check("mr_fill", 64'(bus.fill_count), 64'(0));
    check("mr_ready", 64'(bus.in_ready), 64'(1));
    drive(0, 1, 16'h0011, 0, 0);
    drive(0, 1, 16'h0022, 0, 0);
    drive(0, 1, 16'h0033, 0, 0);
    drive(0, 1, 16'h0044, 0, 0);
    drive(0, 0, 0, 0, 1);
    check("mr_fresh_valid", 64'(bus.vec_valid), 64'(1));
    check("mr_fresh_vector", bus.vector, 64'h0044_0033_0022_0011);

    // Random traffic against the queue model, with occasional resets.
    drive(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_v    = ($urandom_range(0, 3) != 0);
      r_last = ($urandom_range(0, 4) == 0);
      r_vr   = ($urandom_range(0, 1) == 1);
      r_d    = 16'($urandom);
      drive(r_rst, r_v, r_d, r_last, r_vr);
      check("rnd_ready", 64'(bus.in_ready), 64'(!r_rst && mq.size() < 2));
      check("rnd_valid", 64'(bus.vec_valid), 64'(mq.size() > 0));
      check("rnd_fill", 64'(bus.fill_count), 64'(part.size()));
      if (mq.size() > 0) check("rnd_vector", bus.vector, mq[0]);
      model_step(r_rst, r_v, r_d, r_last, r_vr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
